// File: rtl/cl_mult_pkg.sv
// rtl/cl_mult_pkg.sv - shared state encoding and mode constants for the shift-add multiplier
package cl_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic CARRY_LESS = 1'b0;
  localparam logic CARRY_INT  = 1'b1;

endpackage

// File: rtl/cl_rca_adder.sv
// rtl/cl_rca_adder.sv - ripple-carry adder that degrades to a bitwise XOR when carries are disabled
module cl_rca_adder #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  carry_option,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  co
);

  logic [DATA_WIDTH:0] carry;

  assign carry[0] = 1'b0;

  // Gating every stage's carry with carry_option turns the chain into GF(2) addition.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = carry_option & ((a[i] & b[i]) | (carry[i] & (a[i] ^ b[i])));
  end

  assign co = carry[DATA_WIDTH];

endmodule

// File: rtl/cl_shift_add_mult.sv
// rtl/cl_shift_add_mult.sv - sequential shift-and-add multiplier, integer or carry-less per operation
module cl_shift_add_mult
  import cl_mult_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    carry_option,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   m_reg;
  logic [2*DATA_WIDTH-1:0] p_reg;
  logic                    mode_reg;
  logic [CNT_W-1:0]        cnt;

  logic [DATA_WIDTH-1:0]   add_sum;
  logic                    add_co;
  logic [DATA_WIDTH-1:0]   step_s;
  logic                    step_c;
  logic [2*DATA_WIDTH-1:0] p_step;

  cl_rca_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
    .carry_option (mode_reg),
    .a            (p_reg[2*DATA_WIDTH-1:DATA_WIDTH]),
    .b            (m_reg),
    .sum          (add_sum),
    .co           (add_co)
  );

  // The multiplier bit being consumed sits at p_reg[0]; the shift retires it.
  assign step_s = p_reg[0] ? add_sum : p_reg[2*DATA_WIDTH-1:DATA_WIDTH];
  assign step_c = p_reg[0] & add_co;
  assign p_step = {step_c, step_s, p_reg[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)     state_next = RUN;
      RUN:     if (cnt == '0)    state_next = DONE;
      DONE:    if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg    <= '0;
      p_reg    <= '0;
      mode_reg <= CARRY_LESS;
      cnt      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg    <= a;
            p_reg    <= {{DATA_WIDTH{1'b0}}, b};
            mode_reg <= carry_option;
            cnt      <= CNT_W'(DATA_WIDTH - 1);
          end
        end
        RUN: begin
          p_reg <= p_step;
          cnt   <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = p_reg;

endmodule

// File: tb/tb_cl_shift_add_mult.sv
// tb/tb_cl_shift_add_mult.sv - directed and model-checked bench for cl_shift_add_mult at W=8 and W=32
module tb_cl_shift_add_mult;
  import cl_mult_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        iv8 = 1'b0, cm8 = 1'b0, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, busy8;
  logic [15:0] p8;

  logic        iv32 = 1'b0, cm32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, ov32, busy32;
  logic [63:0] p32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cl_shift_add_mult #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .carry_option(cm8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
  );

  cl_shift_add_mult #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .carry_option(cm32),
    .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .product(p32), .busy(busy32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic md, input int w);
    logic [63:0] r;
    r = '0;
    if (md == CARRY_INT) begin
      r = {32'b0, x} * {32'b0, y};
    end else begin
      for (int i = 0; i < w; i++)
        if (y[i]) r = r ^ ({32'b0, x} << i);
    end
    return r;
  endfunction

  // Issues one op, waits (bounded) for out_valid, then accepts the result.
  task automatic run_op(input bit wide, input logic [31:0] av, input logic [31:0] bv,
                        input logic md, output logic [63:0] prod, output int lat);
    if (wide) begin a32 = av; b32 = bv; cm32 = md; iv32 = 1'b1; end
    else      begin a8 = av[7:0]; b8 = bv[7:0]; cm8 = md; iv8 = 1'b1; end
    @(posedge clk); #1;
    iv8 = 1'b0; iv32 = 1'b0;
    lat = 0;
    while (!(wide ? ov32 : ov8) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = wide ? p32 : {48'b0, p8};
    if (wide) or32 = 1'b1; else or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0; or32 = 1'b0;
  endtask

  initial begin
    logic [63:0] prod;
    int lat;
    int acc_t[$];
    bit saw_ov;
    logic [31:0] ra, rb;

    #1;
    chk("reset_in_ready", {63'b0, ir8}, 64'd1);
    chk("reset_out_valid", {63'b0, ov8}, 64'd0);
    chk("reset_busy", {63'b0, busy8}, 64'd0);
    chk("reset_product", {48'b0, p8}, 64'd0);
    chk("reset_product32", p32, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(1'b0, 32'hFF, 32'hFF, CARRY_INT, prod, lat);
    chk("int_ff_ff", prod, 64'hFE01);
    chk("latency_w8", 64'(lat + 1), 64'd9);
    run_op(1'b0, 32'hFF, 32'hFF, CARRY_LESS, prod, lat);
    chk("clmul_ff_ff", prod, 64'h5555);
    run_op(1'b0, 32'h07, 32'h03, CARRY_LESS, prod, lat);
    chk("clmul_07_03", prod, 64'h0009);
    run_op(1'b0, 32'h07, 32'h03, CARRY_INT, prod, lat);
    chk("int_07_03", prod, 64'h0015);

    // Back-pressure with stray in_valid pulses during RUN and DONE.
    a8 = 8'h07; b8 = 8'h03; cm8 = CARRY_INT; iv8 = 1'b1;
    @(posedge clk); #1;
    a8 = 8'hFF; b8 = 8'hFF; cm8 = CARRY_LESS;
    for (int i = 0; i < 8; i++) begin
      chk("run_in_ready", {63'b0, ir8}, 64'd0);
      chk("run_busy", {63'b0, busy8}, 64'd1);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {63'b0, ov8}, 64'd1);
      chk("bp_product", {48'b0, p8}, 64'h0015);
      chk("bp_in_ready", {63'b0, ir8}, 64'd0);
      @(posedge clk); #1;
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
    chk("post_accept_in_ready", {63'b0, ir8}, 64'd1);
    chk("post_accept_out_valid", {63'b0, ov8}, 64'd0);
    chk("idle_product_held", {48'b0, p8}, 64'h0015);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_product_still_held", {48'b0, p8}, 64'h0015);

    // Reset at RUN step 4.
    a8 = 8'hFF; b8 = 8'hFF; cm8 = CARRY_INT; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_busy", {63'b0, busy8}, 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {63'b0, ir8}, 64'd1);
    chk("midrst_out_valid", {63'b0, ov8}, 64'd0);
    chk("midrst_busy", {63'b0, busy8}, 64'd0);
    chk("midrst_product", {48'b0, p8}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_ov = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov8) saw_ov = 1'b1;
    end
    chk("no_ov_after_reset", {63'b0, saw_ov}, 64'd0);
    run_op(1'b0, 32'h0F, 32'h0F, CARRY_INT, prod, lat);
    chk("int_0f_0f_after_reset", prod, 64'h00E1);

    // Streaming: in_valid and out_ready held high.
    a8 = 8'h0B; b8 = 8'h05; cm8 = CARRY_INT; iv8 = 1'b1; or8 = 1'b1;
    for (int t = 0; t < 40 && acc_t.size() < 3; t++) begin
      if (ir8) acc_t.push_back(t);
      @(posedge clk); #1;
      if (ov8) chk("stream_product", {48'b0, p8}, 64'h0037);
    end
    iv8 = 1'b0;
    while (busy8 && acc_t.size() == 3) begin
      @(posedge clk); #1;
      if (!busy8) break;
    end
    or8 = 1'b0;
    chk("stream_count", 64'(acc_t.size()), 64'd3);
    if (acc_t.size() == 3) begin
      chk("stream_gap1", 64'(acc_t[1] - acc_t[0]), 64'd10);
      chk("stream_gap2", 64'(acc_t[2] - acc_t[1]), 64'd10);
    end
    @(posedge clk); #1;

    // Model-checked vectors including zero and all-ones, both widths and modes.
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 8; k++) begin
        for (int md = 0; md < 2; md++) begin
          if (k == 0)      begin ra = '0; rb = 32'hFFFF_FFFF; end
          else if (k == 1) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
          else if (k == 2) begin ra = 32'hFFFF_FFFF; rb = '0; end
          else             begin ra = $urandom; rb = $urandom; end
          if (w == 0) begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
          run_op(w[0], ra, rb, md[0], prod, lat);
          chk(w == 0 ? "model_w8" : "model_w32", prod,
              ref_mul(ra, rb, md[0], w == 0 ? 8 : 32));
          if (w == 1 && k == 1)
            chk("latency_w32", 64'(lat + 1), 64'd33);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cl_shift_add_mult.md
# cl_shift_add_mult

Sequential shift-and-add multiplier that drives one `cl_rca_adder` instance and consumes its sum and carry every cycle. It produces either an integer product or a carry-less (GF(2) polynomial) product of two `DATA_WIDTH`-bit operands. The mode is selected per operation. The block sits directly upstream of the ripple-carry/carry-less adder stage and presents results on a valid/ready handshake to the downstream reduction or comparison logic.

## Interface
- `DATA_WIDTH`, default 32: operand width; legal values are ≥ 2. The product width is `2*DATA_WIDTH`.
- Clock/reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- `clk` input 1: clock, rising-edge active.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: the operands and mode are valid.
- `in_ready` output 1: the block can accept an operation (high only in IDLE).
- `carry_option` input 1: 1 = integer multiply (carry propagates); 0 = carry-less multiply (XOR, carry forced to 0).
- `a` input DATA_WIDTH: multiplicand.
- `b` input DATA_WIDTH: multiplier.
- `out_valid` output 1: `product` is valid.
- `out_ready` input 1: downstream accepts `product`.
- `product` output 2*DATA_WIDTH: result. Bits `[DATA_WIDTH-1:0]` are the low half.
- `busy` output 1: high in RUN and DONE.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: iterating.
  - DONE: `out_valid`=1.
- IDLE→RUN on `in_valid && in_ready`. On that transfer the block latches:
  - multiplicand register M ← `a`;
  - P ← {`DATA_WIDTH`'b0, `b`};
  - mode register ← `carry_option`;
  - counter ← `DATA_WIDTH`-1.
- Each RUN cycle performs one step:
  - If P[0]=1: {c, s} = P[2W-1:W] + M via the adder in the latched mode (c=0 in carry-less mode). Otherwise {c, s} = {0, P[2W-1:W]}.
  - P ← {c, s, P[W-1:0]} >> 1, keeping the low 2W bits.
  - The counter decrements.
- RUN→DONE on the step taken with counter = 0, so there are exactly `DATA_WIDTH` steps.
- DONE→IDLE on `out_ready`. `product` = P and is held stable until it is accepted.
- `product` keeps its last value in IDLE. It only changes during RUN.
- Inputs are ignored outside IDLE:
  - `in_valid` is ignored in RUN and DONE.
  - `a`, `b` and `carry_option` changes have no effect after acceptance.
  - `out_ready` is ignored outside DONE.
- Width rules:
  - The integer result is exact and never overflows 2W bits. For example, all-ones × all-ones = 2^(2W) − 2^(W+1) + 1.
  - The carry-less result has its top bit always 0, since its degree is ≤ 2W−2.
- Zero operands need no special case: the full W steps still run and the result is 0.

## Timing
- Reset value of every output: `in_ready`=1, `out_valid`=0, `busy`=0, `product`=0.
- Internal reset values: state IDLE, counter 0, M=0, mode=0.
- Asserting `rst` mid-operation (RUN or DONE) aborts the operation immediately. The pending result is discarded and no `out_valid` pulse occurs after release.
- Latency: an operation accepted in cycle T has RUN in cycles T+1 … T+W, and `out_valid` rises in cycle T+W+1.
- Acceptance and throughput:
  - The DONE→IDLE handshake cycle cannot accept a new operation. The earliest next acceptance is the cycle after `out_ready`.
  - Back-to-back throughput is one operation per W+2 cycles when `out_ready` is held high.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from inputs.
- The adder path (`cl_rca_adder`, W bits ripple) plus the shift multiplexer is the critical path within one cycle.

## Structure
- Shared package `cl_mult_pkg` holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - mode constants CARRY_LESS=1'b0 and CARRY_INT=1'b1.
- One sub-module instance: `cl_rca_adder #(.DATA_WIDTH(DATA_WIDTH))`.
  - `carry_option` connects to the latched mode; `a` to P's high half; `b` to M.
  - `sum` and `co` are consumed as s and c.
- The counter is `$clog2(DATA_WIDTH)` bits wide.
- Everything else is local: FSM, M/P/mode registers and counter.

## Test plan
- W=8, integer, a=8'hFF, b=8'hFF → `product`=16'hFE01. `out_valid` first seen 9 cycles after acceptance.
- W=8, carry-less, a=8'hFF, b=8'hFF → 16'h5555. Then a=8'h07, b=8'h03: carry-less → 16'h0009, integer → 16'h0015.
- Back-pressure: `out_ready`=0 for 5 cycles in DONE → `product` and `out_valid` stay stable, and `in_ready`=0 throughout. `in_valid` pulses with different operands during RUN and DONE are ignored.
- Reset at RUN step 4 of W=8 → `out_valid` never asserts, all outputs return to reset values, and the next accepted op (0x0F × 0x0F integer) yields 16'h00E1.
- Streaming with `in_valid`/`out_ready` held high, 3 ops → acceptances spaced exactly W+2 cycles apart.
- Randomized W=8 and W=32 compared against the reference model (integer `*`, and carry-less XOR-shift), including zero and all-ones operands in both modes.
